// File: rtl/seq_divider.sv
// Multi-cycle radix-2 non-restoring divider for RV32M DIV/DIVU/REM/REMU, one quotient bit per clock.
// Build option: SEQ_DIVIDER_EARLY_OUT_EN finishes divide-by-zero and signed overflow at acceptance.
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [1:0]       req_op_i,
    input  logic [WIDTH-1:0] req_dividend_i,
    input  logic [WIDTH-1:0] req_divisor_i,
    output logic             resp_valid_o,
    input  logic             resp_ready_i,
    output logic [WIDTH-1:0] resp_data_o
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_SIGN,
        S_DONE
    } state_t;

    state_t           state_q;
    logic [1:0]       op_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH:0]   rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH:0]   dvsr_q;
    logic [WIDTH-1:0] dvnd_q;
    logic             neg_quo_q;
    logic             neg_rem_q;
    logic             dz_q;
    logic             ovf_q;
    logic             resp_valid_q;
    logic [WIDTH-1:0] resp_data_q;

    logic             in_signed;
    logic             in_a_neg;
    logic             in_b_neg;
    logic [WIDTH-1:0] in_a_mag;
    logic [WIDTH-1:0] in_b_mag;
    logic             in_dz;
    logic             in_ovf;

    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   rem_d;
    logic [WIDTH-1:0] quo_d;
    logic [WIDTH:0]   rem_fix;
    logic [WIDTH-1:0] quo_s;
    logic [WIDTH-1:0] rem_s;
    logic [WIDTH-1:0] result_d;

    // Operand decode at acceptance; the magnitude of the most negative value fits as unsigned.
    always_comb begin
        in_signed = ~req_op_i[0];
        in_a_neg  = in_signed & req_dividend_i[WIDTH-1];
        in_b_neg  = in_signed & req_divisor_i[WIDTH-1];
        in_a_mag  = in_a_neg ? -req_dividend_i : req_dividend_i;
        in_b_mag  = in_b_neg ? -req_divisor_i : req_divisor_i;
        in_dz     = (req_divisor_i == '0);
        in_ovf    = in_signed & (req_dividend_i == {1'b1, {(WIDTH-1){1'b0}}})
                    & (req_divisor_i == '1);
    end

`ifdef SEQ_DIVIDER_EARLY_OUT_EN
    logic [WIDTH-1:0] early_data;

    always_comb begin
        early_data = '0;
        if (in_dz)
            early_data = req_op_i[1] ? req_dividend_i : '1;
        else
            early_data = req_op_i[1] ? '0 : req_dividend_i;
    end
`endif

    // One non-restoring step, then the final remainder correction and sign fix-up.
    always_comb begin
        rem_sh  = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
        rem_d   = rem_q[WIDTH] ? (rem_sh + dvsr_q) : (rem_sh - dvsr_q);
        quo_d   = {quo_q[WIDTH-2:0], ~rem_d[WIDTH]};
        rem_fix = rem_q[WIDTH] ? (rem_q + dvsr_q) : rem_q;
        quo_s   = neg_quo_q ? -quo_q : quo_q;
        rem_s   = neg_rem_q ? -rem_fix[WIDTH-1:0] : rem_fix[WIDTH-1:0];
        if (dz_q)
            result_d = op_q[1] ? dvnd_q : '1;
        else if (ovf_q)
            result_d = op_q[1] ? '0 : dvnd_q;
        else
            result_d = op_q[1] ? rem_s : quo_s;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            op_q         <= '0;
            cnt_q        <= '0;
            rem_q        <= '0;
            quo_q        <= '0;
            dvsr_q       <= '0;
            dvnd_q       <= '0;
            neg_quo_q    <= 1'b0;
            neg_rem_q    <= 1'b0;
            dz_q         <= 1'b0;
            ovf_q        <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid_i) begin
                        op_q      <= req_op_i;
                        cnt_q     <= CW'(WIDTH);
                        rem_q     <= '0;
                        quo_q     <= in_a_mag;
                        dvsr_q    <= {1'b0, in_b_mag};
                        dvnd_q    <= req_dividend_i;
                        neg_quo_q <= in_a_neg ^ in_b_neg;
                        neg_rem_q <= in_a_neg;
                        dz_q      <= in_dz;
                        ovf_q     <= in_ovf;
                        state_q   <= S_CALC;
`ifdef SEQ_DIVIDER_EARLY_OUT_EN
                        if (in_dz || in_ovf) begin
                            resp_data_q  <= early_data;
                            resp_valid_q <= 1'b1;
                            state_q      <= S_DONE;
                        end
`endif
                    end
                end
                S_CALC: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CW'(1))
                        state_q <= S_SIGN;
                end
                S_SIGN: begin
                    resp_data_q  <= result_d;
                    resp_valid_q <= 1'b1;
                    state_q      <= S_DONE;
                end
                S_DONE: begin
                    if (resp_ready_i) begin
                        resp_valid_q <= 1'b0;
                        state_q      <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ready_o  = (state_q == S_IDLE);
    assign resp_valid_o = resp_valid_q;
    assign resp_data_o  = resp_data_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: vector table, random ops against a behavioural model,
// backpressure and mid-operation reset sequences.
module tb_seq_divider;

    localparam int W = 32;
    localparam int LAT_NORM = W + 2;
`ifdef SEQ_DIVIDER_EARLY_OUT_EN
    localparam int LAT_SPEC = 1;
`else
    localparam int LAT_SPEC = W + 2;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [1:0]   req_op = 2'b00;
    logic [W-1:0] req_dividend = '0;
    logic [W-1:0] req_divisor = '0;
    logic         resp_valid;
    logic         resp_ready = 1'b1;
    logic [W-1:0] resp_data;

    int n_cmp = 0;
    int n_err = 0;
    logic [W-1:0] exp_q[$];

    seq_divider #(.WIDTH(W)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_op_i       (req_op),
        .req_dividend_i (req_dividend),
        .req_divisor_i  (req_divisor),
        .resp_valid_o   (resp_valid),
        .resp_ready_i   (resp_ready),
        .resp_data_o    (resp_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp;
        bit           special;
        string        name;
    } vec_t;

    localparam logic [1:0] DIV = 2'b00, DIVU = 2'b01, REM = 2'b10, REMU = 2'b11;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] model(input logic [1:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        logic signed [W-1:0] sa, sb;
        logic ovf;
        sa  = a;
        sb  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            DIV:     model = (b == 0) ? '1 : ovf ? a : W'(sa / sb);
            DIVU:    model = (b == 0) ? '1 : a / b;
            REM:     model = (b == 0) ? a : ovf ? '0 : W'(sa % sb);
            default: model = (b == 0) ? a : a % b;
        endcase
    endfunction

    task automatic wait_resp(input int lat, input string name);
        int n;
        logic [W-1:0] e;
        n = 1;
        while (!resp_valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk({name, " latency"}, W'(n), W'(lat));
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({name, " data"}, resp_data, e);
        end
    endtask

    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp, input int lat, input string name);
        @(negedge clk);
        req_op = op; req_dividend = a; req_divisor = b; req_valid = 1'b1;
        chk({name, " req_ready idle"}, W'(req_ready), 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        exp_q.push_back(exp);
        wait_resp(lat, name);
        @(posedge clk); #1;
        chk({name, " resp_valid after hs"}, W'(resp_valid), 0);
        chk({name, " req_ready after hs"}, W'(req_ready), 1);
    endtask

    vec_t vt [18];

    initial begin
        vt[0]  = '{DIVU, 32'd100,        32'd7,          32'd14,         0, "divu_100_7"};
        vt[1]  = '{REMU, 32'd100,        32'd7,          32'd2,          0, "remu_100_7"};
        vt[2]  = '{DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  0, "div_m7_2"};
        vt[3]  = '{REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  0, "rem_m7_2"};
        vt[4]  = '{REM,  32'd7,          32'hFFFF_FFFE,  32'd1,          0, "rem_7_m2"};
        vt[5]  = '{DIV,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  0, "div_7_m2"};
        vt[6]  = '{DIVU, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  1, "divu_by0"};
        vt[7]  = '{REMU, 32'h1234_5678,  32'd0,          32'h1234_5678,  1, "remu_by0"};
        vt[8]  = '{DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1, "div_ovf"};
        vt[9]  = '{REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1, "rem_ovf"};
        vt[10] = '{DIV,  32'h8000_0000,  32'd0,          32'hFFFF_FFFF,  1, "div_neg_by0"};
        vt[11] = '{REM,  32'h8000_0000,  32'd0,          32'h8000_0000,  1, "rem_neg_by0"};
        vt[12] = '{DIV,  32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         0, "div_m100_m7"};
        vt[13] = '{REM,  32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'hFFFF_FFFE,  0, "rem_m100_m7"};
        vt[14] = '{DIVU, 32'hFFFF_FFFF,  32'd10,         32'h1999_9999,  0, "divu_max_10"};
        vt[15] = '{REMU, 32'hFFFF_FFFF,  32'd10,         32'd5,          0, "remu_max_10"};
        vt[16] = '{DIV,  32'h8000_0000,  32'd2,          32'hC000_0000,  0, "div_min_2"};
        vt[17] = '{REMU, 32'd5,          32'd10,         32'd5,          0, "remu_5_10"};

        repeat (3) @(posedge clk);
        #1;
        chk("reset req_ready", W'(req_ready), 1);
        chk("reset resp_valid", W'(resp_valid), 0);
        chk("reset resp_data", resp_data, 0);
        rst = 1'b0;

        for (int i = 0; i < 18; i++)
            run_op(vt[i].op, vt[i].a, vt[i].b, vt[i].exp,
                   vt[i].special ? LAT_SPEC : LAT_NORM, vt[i].name);

        for (int i = 0; i < 16; i++) begin
            logic [1:0]   op;
            logic [W-1:0] a, b;
            op = 2'($urandom_range(0, 3));
            a  = $urandom();
            b  = (i % 3 == 0) ? W'($urandom_range(1, 1000)) : $urandom();
            if (i % 3 == 1) b = -b;
            run_op(op, a, b, model(op, a, b), LAT_NORM, "random");
        end

        // Backpressure: hold the response 10 cycles while a second request waits.
        resp_ready = 1'b0;
        @(negedge clk);
        req_op = DIVU; req_dividend = 32'd1000; req_divisor = 32'd10; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        exp_q.push_back(32'd100);
        wait_resp(LAT_NORM, "bp_first");
        req_op = DIVU; req_dividend = 32'd50; req_divisor = 32'd5; req_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("bp resp_valid held", W'(resp_valid), 1);
            chk("bp resp_data stable", resp_data, 32'd100);
            chk("bp req_ready low", W'(req_ready), 0);
            @(posedge clk); #1;
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp resp_valid after hs", W'(resp_valid), 0);
        chk("bp req_ready idle", W'(req_ready), 1);
        @(posedge clk); #1;
        chk("bp second accepted", W'(req_ready), 0);
        req_valid = 1'b0;
        exp_q.push_back(32'd10);
        wait_resp(LAT_NORM, "bp_second");
        @(posedge clk); #1;
        chk("bp2 req_ready after hs", W'(req_ready), 1);

        // Reset during CALC discards the operation.
        @(negedge clk);
        req_op = DIVU; req_dividend = 32'h0000_FFFF; req_divisor = 32'd3; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (14) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst resp_valid", W'(resp_valid), 0);
        chk("rst resp_data", resp_data, 0);
        chk("rst req_ready", W'(req_ready), 1);
        repeat (40) begin
            @(posedge clk); #1;
            chk("rst no stale resp", W'(resp_valid), 0);
        end
        run_op(DIVU, 32'd9, 32'd3, 32'd3, LAT_NORM, "divu_9_3_after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
